// File: rtl/md5_message_padder.sv
// MD5 message padder: packs 32-bit words into 512-bit blocks, appends 0x80, zero fill and 64-bit LE bit length.
// Optional MD5_PAD_BYTESWAP_EN: treat in_data as big-endian (byte 0 = in_data[31:24]).
module md5_message_padder #(
  parameter int LEN_W = 64
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [31:0]  in_data,
  input  logic [2:0]   in_nbytes,
  input  logic         in_last,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [511:0] block_data,
  output logic         block_last,
  output logic         block_valid,
  input  logic         block_ready,
  output logic [1:0]   o_dbg_state
);

  // Handshake: a word moves when in_valid & in_ready at a rising edge, a block moves when
  // block_valid & block_ready; block_data/block_last never change while block_valid waits.
  typedef enum logic [1:0] {S_FILL, S_PAD, S_EMIT, S_TAIL} state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [3:0]         r_word_idx;
  logic [511:0]       r_buf;
  logic [LEN_W-1:0]   r_bit_len;
  logic [6:0]         r_p;
  logic               r_tail_pending;
  logic               r_tail_80;
  logic [511:0]       r_block_data;
  logic               r_block_last;

  logic [31:0]        w_word;
  logic [31:0]        w_word_m;
  logic [2:0]         w_nb;
  logic               w_in_fire;
  logic [511:0]       w_buf_next;
  logic [511:0]       w_pad_block;
  logic [511:0]       w_tail_block;
  logic [63:0]        w_len64;
  logic [LEN_W-1:0]   w_len_add;

`ifdef MD5_PAD_BYTESWAP_EN
  assign w_word = {in_data[7:0], in_data[15:8], in_data[23:16], in_data[31:24]};
`else
  assign w_word = in_data;
`endif

  assign w_in_fire = in_valid & in_ready;
  assign w_len64   = 64'(r_bit_len);
  assign w_len_add = LEN_W'({w_nb, 3'b000});

  always_comb begin
    w_nb = 3'd4;
    if (in_last && (in_nbytes <= 3'd4)) w_nb = in_nbytes;
  end

  // Bytes past the final valid byte are forced to zero before they enter the buffer.
  always_comb begin
    w_word_m = '0;
    for (int j = 0; j < 4; j++) begin
      if (3'(j) < w_nb) w_word_m[8*j +: 8] = w_word[8*j +: 8];
    end
  end

  always_comb begin
    w_buf_next = r_buf;
    w_buf_next[{r_word_idx, 5'b00000} +: 32] = w_word_m;
  end

  // r_p is the byte position right after the final data byte (0..64).
  always_comb begin
    w_pad_block = '0;
    for (int b = 0; b < 64; b++) begin
      if (7'(b) < r_p)       w_pad_block[8*b +: 8] = r_buf[8*b +: 8];
      else if (7'(b) == r_p) w_pad_block[8*b +: 8] = 8'h80;
    end
    if (r_p <= 7'd55) w_pad_block[511:448] = w_len64;
  end

  always_comb begin
    w_tail_block          = '0;
    w_tail_block[7:0]     = r_tail_80 ? 8'h80 : 8'h00;
    w_tail_block[511:448] = w_len64;
  end

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_FILL;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    in_ready     = 1'b0;
    block_valid  = 1'b0;
    case (r_state)
      S_FILL: begin
        in_ready = 1'b1;
        if (w_in_fire) begin
          if (in_last)                  w_next_state = S_PAD;
          else if (r_word_idx == 4'd15) w_next_state = S_EMIT;
        end
      end
      S_PAD: w_next_state = S_EMIT;
      S_EMIT: begin
        block_valid = 1'b1;
        if (block_ready) w_next_state = r_tail_pending ? S_TAIL : S_FILL;
      end
      S_TAIL: begin
        block_valid = 1'b1;
        if (block_ready) w_next_state = S_FILL;
      end
      default: w_next_state = S_FILL;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_word_idx     <= '0;
      r_buf          <= '0;
      r_bit_len      <= '0;
      r_p            <= '0;
      r_tail_pending <= 1'b0;
      r_tail_80      <= 1'b0;
      r_block_data   <= '0;
      r_block_last   <= 1'b0;
    end else begin
      case (r_state)
        S_FILL: begin
          if (w_in_fire) begin
            r_buf     <= w_buf_next;
            r_bit_len <= r_bit_len + w_len_add;
            if (in_last) begin
              r_p        <= 7'({r_word_idx, 2'b00}) + 7'(w_nb);
              r_word_idx <= '0;
            end else if (r_word_idx == 4'd15) begin
              r_block_data   <= w_buf_next;
              r_block_last   <= 1'b0;
              r_tail_pending <= 1'b0;
              r_word_idx     <= '0;
            end else begin
              r_word_idx <= r_word_idx + 4'd1;
            end
          end
        end
        S_PAD: begin
          r_block_data   <= w_pad_block;
          r_block_last   <= (r_p <= 7'd55);
          r_tail_pending <= (r_p > 7'd55);
          r_tail_80      <= (r_p == 7'd64);
        end
        S_EMIT: begin
          if (block_ready) begin
            if (r_tail_pending) begin
              r_block_data   <= w_tail_block;
              r_block_last   <= 1'b1;
              r_tail_pending <= 1'b0;
            end else if (r_block_last) begin
              r_bit_len <= '0;
              r_buf     <= '0;
            end
          end
        end
        S_TAIL: begin
          if (block_ready) begin
            r_bit_len <= '0;
            r_buf     <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign block_data  = r_block_data;
  assign block_last  = r_block_last;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_md5_message_padder.sv
// Bench for md5_message_padder: directed MD5 padding cases plus random messages checked
// against a byte-queue padding model through an expected-block scoreboard.
module tb_md5_message_padder;

  logic         clock = 1'b0;
  logic         reset;
  logic [31:0]  in_data;
  logic [2:0]   in_nbytes;
  logic         in_last;
  logic         in_valid;
  logic         in_ready;
  logic [511:0] block_data;
  logic         block_last;
  logic         block_valid;
  logic         block_ready;
  logic [1:0]   dbg_state;

  md5_message_padder #(.LEN_W(64)) dut (
    .clock       (clock),
    .reset       (reset),
    .in_data     (in_data),
    .in_nbytes   (in_nbytes),
    .in_last     (in_last),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .block_data  (block_data),
    .block_last  (block_last),
    .block_valid (block_valid),
    .block_ready (block_ready),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  int           errors = 0;
  int           checks = 0;
  logic [512:0] exp_q[$];
  logic [512:0] mon_exp;
  int           ready_mode = 2;   // 0 random, 1 hold low, 2 hold high
  bit           idle_en = 1'b0;
  int           acc_cnt = 0;

  task automatic check(input string name, input logic [512:0] act, input logic [512:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pulse_reset();
    @(posedge clock); #1;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  // ---------------- reference model ----------------
  task automatic push_expected(input logic [7:0] msg[$]);
    logic [7:0]   pad[$];
    logic [63:0]  bl;
    logic [511:0] d;
    int           nblk;
    pad = msg;
    bl  = 64'(msg.size()) * 64'd8;
    pad.push_back(8'h80);
    while (pad.size() % 64 != 56) pad.push_back(8'h00);
    for (int k = 0; k < 8; k++) pad.push_back(bl[8*k +: 8]);
    nblk = pad.size() / 64;
    for (int blk = 0; blk < nblk; blk++) begin
      for (int b = 0; b < 64; b++) d[8*b +: 8] = pad[blk*64 + b];
      exp_q.push_back({1'(blk == nblk - 1), d});
    end
  endtask

  function automatic logic [31:0] pack(input logic [7:0] b0, input logic [7:0] b1,
                                       input logic [7:0] b2, input logic [7:0] b3);
`ifdef MD5_PAD_BYTESWAP_EN
    return {b0, b1, b2, b3};
`else
    return {b3, b2, b1, b0};
`endif
  endfunction

  // ---------------- drivers ----------------
  task automatic send_word(input logic [31:0] d, input logic [2:0] nb, input logic last);
    int n;
    in_data = d; in_nbytes = nb; in_last = last; in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clock);
      if (in_ready) break;
      n++;
      if (n > 2000) begin
        checks++; errors++;
        $display("FAIL in_ready_timeout: got in_ready=0 for %0d cycles expected accept", n);
        break;
      end
    end
    @(posedge clock); #1;
    in_valid = 1'b0;
    if (idle_en) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clock); #1;
      end
    end
  endtask

  // garbage=1 randomises invalid bytes, in_nbytes on non-last words and the terminator style
  task automatic send_msg(input logic [7:0] msg[$], input bit garbage);
    int         n, nfull, r, nw, vb;
    bit         zero_term, last;
    logic [7:0] bb[4];
    logic [2:0] nb;
    push_expected(msg);
    n = msg.size(); nfull = n / 4; r = n % 4;
    zero_term = (n == 0) || (garbage && r == 0 && $urandom_range(0, 3) == 0);
    nw = nfull + ((r != 0 || zero_term) ? 1 : 0);
    for (int i = 0; i < nw; i++) begin
      last = (i == nw - 1);
      vb   = (i < nfull) ? 4 : r;
      for (int j = 0; j < 4; j++)
        bb[j] = (j < vb) ? msg[4*i + j] : (garbage ? 8'($urandom) : 8'h00);
      if (!last)        nb = garbage ? 3'($urandom_range(0, 7)) : 3'd4;
      else if (vb == 4) nb = garbage ? 3'($urandom_range(4, 7)) : 3'd4;
      else              nb = 3'(vb);
      send_word(pack(bb[0], bb[1], bb[2], bb[3]), nb, last);
    end
  endtask

  // called right after the final word was accepted; the final block appears two cycles later
  task automatic check_final_latency(input string name);
    check({name, "_valid_t0"}, block_valid, 1'b0);
    @(negedge clock);
    check({name, "_valid_t1"}, block_valid, 1'b0);
    @(negedge clock);
    check({name, "_valid_t2"}, block_valid, 1'b1);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(posedge clock); n++;
    end
    check({name, "_drain_left"}, 513'(exp_q.size()), 513'd0);
    exp_q.delete();
  endtask

  initial begin
    block_ready = 1'b0;
    forever begin
      @(posedge clock); #1;
      case (ready_mode)
        0:       block_ready = ($urandom_range(0, 3) != 0);
        1:       block_ready = 1'b0;
        default: block_ready = 1'b1;
      endcase
    end
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clock) begin
    if (!reset && block_valid && block_ready) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_block: got %h expected no block", {block_last, block_data});
      end else begin
        mon_exp = exp_q.pop_front();
        check("block", {block_last, block_data}, mon_exp);
      end
    end
    if (!reset && in_valid && in_ready) acc_cnt++;
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0]   msg[$];
    logic [512:0] first_blk;
    int           base, n;

    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_nbytes = '0; in_last = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("rst_block_valid", block_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_block_data", block_data, 512'd0);
    check("rst_block_last", block_last, 1'b0);
    @(posedge clock); #1;

    // empty message
    msg = {};
    send_msg(msg, 1'b0);
    check_final_latency("empty");
    drain("empty");

    // "abc"
    msg = {8'h61, 8'h62, 8'h63};
    send_msg(msg, 1'b0);
    check_final_latency("abc");
    drain("abc");

    // 56 bytes: 0x80 fills the first block, length spills to a second block
    msg = {};
    for (int i = 0; i < 56; i++) msg.push_back(8'h61);
    send_msg(msg, 1'b0);
    drain("len56");

    // 64 bytes: data-only block then tail with 0x80 at byte 0
    msg = {};
    for (int i = 0; i < 64; i++) msg.push_back(8'(i + 1));
    send_msg(msg, 1'b0);
    drain("len64");

    // backpressure: full block held for 5 cycles, 17th word must wait
    ready_mode = 1;
    repeat (2) @(posedge clock);
    #1;
    msg = {};
    for (int i = 0; i < 68; i++) msg.push_back(8'($urandom));
    base = acc_cnt;
    fork
      send_msg(msg, 1'b0);
      begin
        n = 0;
        while (acc_cnt != base + 16 && n < 2000) begin
          @(negedge clock); #1; n++;
        end
        check("bp_words_before_block", 513'(acc_cnt - base), 513'd16);
        first_blk = exp_q[0];
        @(negedge clock);
        check("bp_full_latency_valid", block_valid, 1'b1);
        for (int c = 0; c < 5; c++) begin
          check("bp_held_block", {block_last, block_data}, first_blk);
          check("bp_in_ready_low", in_ready, 1'b0);
          check("bp_no_17th_word", 513'(acc_cnt - base), 513'd16);
          @(negedge clock);
        end
        ready_mode = 2;
      end
    join
    drain("bp");

    // reset with a pending block: block must vanish
    ready_mode = 1;
    for (int i = 0; i < 16; i++) send_word($urandom, 3'd4, 1'b0);
    @(negedge clock);
    check("pend_valid_before_rst", block_valid, 1'b1);
    pulse_reset();
    @(negedge clock);
    check("pend_rst_block_valid", block_valid, 1'b0);
    check("pend_rst_in_ready", in_ready, 1'b1);
    check("pend_rst_block_data", block_data, 512'd0);
    ready_mode = 2;
    repeat (4) @(posedge clock);
    #1;

    // reset after 7 words, then "abc" must come out clean
    for (int i = 0; i < 7; i++) send_word($urandom, 3'd4, 1'b0);
    pulse_reset();
    @(negedge clock);
    check("mid_rst_block_valid", block_valid, 1'b0);
    check("mid_rst_block_last", block_last, 1'b0);
    @(posedge clock); #1;
    msg = {8'h61, 8'h62, 8'h63};
    send_msg(msg, 1'b0);
    check_final_latency("abc_after_rst");
    drain("abc_after_rst");

    // random messages with random gaps and random backpressure
    ready_mode = 0;
    idle_en = 1'b1;
    for (int m = 0; m < 40; m++) begin
      msg = {};
      n = $urandom_range(0, 140);
      for (int i = 0; i < n; i++) msg.push_back(8'($urandom));
      send_msg(msg, 1'b1);
    end
    drain("random");

    repeat (5) @(posedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
